capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
- Controller that sequences the VGA grid sampler for the klotski camera path.
- On a solver request it repeatedly pulses the sampler's start, waits for its done, and thresholds the 8x8 array of 4-bit red accumulations into a 64-bit occupancy map.
- It publishes the map only after STABLE_FRAMES consecutive identical maps, bounded by a retry limit and a per-frame timeout.
- It sits between the grid sampler and the board decoder/solver.

Parameters:
- THRESHOLD, 4'd3: a cell bit is 1 when its red accumulation is strictly greater than this value.
- STABLE_FRAMES, 3: consecutive identical maps required before the result is accepted (range 1..15).
- MAX_TRIES, 16: maximum sampler runs per request (range 1..255).
- TIMEOUT_CYC, 1400000: maximum cycles in WAIT for a sampler done, roughly 2 frames at 1056x628.

Ports:
- i_Clk  input  1  system clock.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  1  capture request pulse; accepted only in S_IDLE.
- i_abort  input  1  returns the block to S_IDLE from any state; takes priority over every other event.
- o_sample_start  output  1  one-cycle start pulse to the sampler.
- i_sample_done  input  1  one-cycle done pulse from the sampler.
- i_red_avg  input  [7:0][7:0][3:0]  sampler accumulations, indexed [row][col]; valid in the cycle of i_sample_done.
- o_map  output  64  accepted occupancy map; bit 8*row+col.
- o_valid  output  1  one-cycle pulse when o_map is updated.
- o_fail  output  1  one-cycle pulse when the retry limit is exhausted or a timeout occurs.
- o_timeout  output  1  sticky flag: the last request ended by timeout; cleared on the next accepted i_req.
- o_busy  output  1  high in every state except S_IDLE.
- o_tries  output  8  number of sampler runs issued for the current request.

Behaviour:
- Reset and clock:
  - All state is synchronous to i_Clk.
  - Reset applies on a rising edge with i_rst high.
  - After reset, every output is 0 and the state is S_IDLE. Internal prev_map, match_cnt, try_cnt and timer are all 0.
- States: S_IDLE, S_START, S_WAIT, S_CHECK, S_DONE, S_FAIL.
- S_IDLE:
  - On i_req, go to S_START.
  - Clear try_cnt and match_cnt, and clear o_timeout.
  - o_map holds its last accepted value.
- S_START:
  - o_sample_start = 1 for exactly this one cycle. It is a registered output, so it is high in the cycle after i_req is accepted.
  - Increment try_cnt, clear timer, go to S_WAIT.
- S_WAIT:
  - timer increments each cycle.
  - If i_sample_done: capture cand[8*r+c] = (i_red_avg[r][c] > THRESHOLD) as an unsigned 4-bit compare, then go to S_CHECK.
  - Else if timer == TIMEOUT_CYC-1: set o_timeout and go to S_FAIL.
  - A done in the same cycle as the timeout wins.
- S_CHECK (one cycle):
  - If match_cnt != 0 and cand == prev_map, match_cnt += 1 (saturating at 15). Otherwise match_cnt = 1.
  - prev_map <= cand in both cases.
  - If the updated match_cnt == STABLE_FRAMES, go to S_DONE.
  - Else if try_cnt == MAX_TRIES, go to S_FAIL.
  - Else go to S_START.
- S_DONE: o_map <= prev_map; o_valid = 1 for one cycle; go to S_IDLE.
- S_FAIL: o_fail = 1 for one cycle; o_map unchanged; go to S_IDLE.
- i_abort:
  - From any state, go to S_IDLE next cycle.
  - No o_valid or o_fail pulse; o_map and o_timeout unchanged.
  - A sampler run already started completes on its own. Its late i_sample_done is ignored in S_IDLE.
- Other ignored inputs:
  - i_req is ignored while o_busy = 1.
  - i_sample_done outside S_WAIT is ignored.
- o_tries mirrors try_cnt and is held after DONE or FAIL until the next accepted request.
- Minimum latency, measured from i_req accepted to o_valid, with sampler latency L cycles counted from o_sample_start to i_sample_done:
  - STABLE_FRAMES = 1: 4 + L cycles.
  - Each additional frame adds 2 + L cycles.
- Reset asserted mid-operation returns to the reset values immediately, with no output pulses.

Test Plan:
- STABLE_FRAMES=3. i_req; sampler returns the same avg three times (all cells 4, cell[2][5] = 1) -> three start pulses, one o_valid, o_map = 64'hFFFF_FFFF_FFFF_FFFF with bit 21 = 0, o_tries = 3.
- Maps A, B, B, B returned -> o_valid after the 4th done, o_map = B, o_tries = 4; a compare of exactly value 3 yields bit 0 and value 4 yields bit 1.
- MAX_TRIES=4, alternating maps A/B -> o_fail pulse after the 4th S_CHECK, no o_valid, o_map unchanged from its prior value, o_tries = 4.
- TIMEOUT_CYC=100, sampler never responds -> o_fail exactly 100 cycles after entering S_WAIT, o_timeout = 1. Next i_req clears o_timeout.
- i_abort during S_WAIT, then a late i_sample_done -> o_busy drops next cycle, no pulses, late done ignored. i_req issued while busy has no effect.
- i_rst high mid-S_WAIT -> all outputs 0 the next cycle, state S_IDLE.

Source files
------------

// File: rtl/capture_sequencer.sv
// ============================================================================
// Module      : capture_sequencer
// Description : Drives the VGA grid sampler and publishes a thresholded 8x8
//               occupancy map once enough consecutive identical maps are seen.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module capture_sequencer #(
    parameter logic [3:0] THRESHOLD     = 4'd3,
    parameter int         STABLE_FRAMES = 3,
    parameter int         MAX_TRIES     = 16,
    parameter int         TIMEOUT_CYC   = 1400000
) (
    input  logic                  i_Clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_abort,
    output logic                  o_sample_start,
    input  logic                  i_sample_done,
    input  logic [7:0][7:0][3:0]  i_red_avg,
    output logic [63:0]           o_map,
    output logic                  o_valid,
    output logic                  o_fail,
    output logic                  o_timeout,
    output logic                  o_busy,
    output logic [7:0]            o_tries
);

    localparam int             TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]  TMO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]     STABLE_LIM = 4'(STABLE_FRAMES);
    localparam logic [7:0]     TRIES_LIM  = 8'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [63:0]    cand_q, cand_d;
    logic [63:0]    prev_q, prev_d;
    logic [63:0]    map_q, map_d;
    logic [3:0]     match_q, match_d;
    logic [7:0]     try_q, try_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           start_q, start_d;
    logic           valid_q, valid_d;
    logic           fail_q, fail_d;
    logic           tmo_q, tmo_d;

    logic [63:0]    w_thresh;
    logic [3:0]     w_match_upd;

    genvar gr, gc;
    generate
        for (gr = 0; gr < 8; gr++) begin : g_row
            for (gc = 0; gc < 8; gc++) begin : g_col
                assign w_thresh[8*gr+gc] = (i_red_avg[gr][gc] > THRESHOLD);
            end
        end
    endgenerate

    // Run length of identical maps, saturating so long runs never wrap to 0.
    always_comb begin
        w_match_upd = 4'd1;
        if ((match_q != 4'd0) && (cand_q == prev_q)) begin
            w_match_upd = (match_q == 4'hF) ? 4'hF : match_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        prev_d  = prev_q;
        map_d   = map_q;
        match_d = match_q;
        try_d   = try_q;
        timer_d = timer_q;
        tmo_d   = tmo_q;
        valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    state_d = S_START;
                    try_d   = 8'd0;
                    match_d = 4'd0;
                    tmo_d   = 1'b0;
                end
            end
            S_START: begin
                try_d   = try_q + 8'd1;
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (i_sample_done) begin
                    cand_d  = w_thresh;
                    state_d = S_CHECK;
                end else if (timer_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_FAIL;
                end
            end
            S_CHECK: begin
                match_d = w_match_upd;
                prev_d  = cand_q;
                if (w_match_upd == STABLE_LIM) begin
                    state_d = S_DONE;
                end else if (try_q == TRIES_LIM) begin
                    state_d = S_FAIL;
                end else begin
                    state_d = S_START;
                end
            end
            S_DONE: begin
                map_d   = prev_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort freezes all bookkeeping and suppresses every pulse.
        if (i_abort) begin
            state_d = S_IDLE;
            cand_d  = cand_q;
            prev_d  = prev_q;
            map_d   = map_q;
            match_d = match_q;
            try_d   = try_q;
            timer_d = timer_q;
            tmo_d   = tmo_q;
            valid_d = 1'b0;
        end

        start_d = (state_d == S_START);
        fail_d  = (state_d == S_FAIL);
    end

    always_ff @(posedge i_Clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            prev_q  <= '0;
            map_q   <= '0;
            match_q <= '0;
            try_q   <= '0;
            timer_q <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            prev_q  <= prev_d;
            map_q   <= map_d;
            match_q <= match_d;
            try_q   <= try_d;
            timer_q <= timer_d;
            start_q <= start_d;
            valid_q <= valid_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
        end
    end

    assign o_sample_start = start_q;
    assign o_map          = map_q;
    assign o_valid        = valid_q;
    assign o_fail         = fail_q;
    assign o_timeout      = tmo_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_tries        = try_q;

endmodule

`default_nettype wire

// File: tb/tb_capture_sequencer.sv
// ============================================================================
// Module      : tb_capture_sequencer
// Description : Self-checking bench for capture_sequencer (vector table,
//               randomized requests against a reference model, corner cases).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_capture_sequencer;

    localparam int SF = 3;
    localparam int MT = 4;
    localparam int TO = 100;

    logic                 clk = 1'b0;
    logic                 i_rst, i_req, i_abort, i_sample_done;
    logic [7:0][7:0][3:0] red;
    logic                 o_sample_start, o_valid, o_fail, o_timeout, o_busy;
    logic [63:0]          o_map;
    logic [7:0]           o_tries;

    capture_sequencer #(
        .THRESHOLD     (4'd3),
        .STABLE_FRAMES (SF),
        .MAX_TRIES     (MT),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .i_Clk          (clk),
        .i_rst          (i_rst),
        .i_req          (i_req),
        .i_abort        (i_abort),
        .o_sample_start (o_sample_start),
        .i_sample_done  (i_sample_done),
        .i_red_avg      (red),
        .o_map          (o_map),
        .o_valid        (o_valid),
        .o_fail         (o_fail),
        .o_timeout      (o_timeout),
        .o_busy         (o_busy),
        .o_tries        (o_tries)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][2:0] sel;
        int              lat;
        bit              ev;
        logic [63:0]     em;
        int              et;
        int              ew;
    } vec_t;

    int                   n_chk = 0;
    int                   n_fail = 0;
    logic [7:0][7:0][3:0] pats [8];
    logic [2:0]           rsel [16];
    int                   rlat [16];
    logic [63:0]          mdl_map;
    vec_t                 vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] thr(input logic [7:0][7:0][3:0] p);
        logic [63:0] m;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                m[8*r+c] = (int'(p[r][c]) > 3);
        return m;
    endfunction

    // Reference: scan the response list for the first run of SF equal maps.
    task automatic model(output bit v, output int tries, output logic [63:0] m, output int when);
        int          run;
        logic [63:0] prev, cur;
        run = 0; prev = '0; when = 0; v = 0; tries = MT; m = mdl_map;
        for (int i = 0; i < MT; i++) begin
            cur  = thr(pats[rsel[i]]);
            when += 2 + rlat[i];
            run  = (i > 0 && cur == prev) ? run + 1 : 1;
            prev = cur;
            if (run == SF) begin
                v = 1; tries = i + 1; m = cur; when += 2;
                return;
            end
        end
        when += 1;
    endtask

    // Issues a request and acts as the sampler until a valid/fail pulse.
    task automatic run_req(input int nresp, output int starts, output bit gv, output bit gf,
                           output int when, output logic [63:0] gmap, output int gtries,
                           output bit gtmo, output bit after);
        int due, idx;
        starts = 0; gv = 0; gf = 0; when = -1; due = -1; idx = 0;
        gmap = '0; gtries = 0; gtmo = 0; after = 0;
        i_req = 1'b1;
        tick();
        i_req = 1'b0;
        for (int t = 1; t < 600; t++) begin
            if (o_valid || o_fail) begin
                gv = o_valid; gf = o_fail; when = t;
                gmap = o_map; gtries = int'(o_tries); gtmo = o_timeout;
                break;
            end
            if (o_sample_start) begin
                starts++;
                if (starts <= nresp) begin
                    idx = starts - 1;
                    due = t + rlat[idx];
                end
            end
            i_sample_done = (t == due);
            if (t == due) red = pats[rsel[idx]];
            tick();
        end
        i_sample_done = 1'b0;
        if (when >= 0) begin
            tick();
            after = o_valid | o_fail | o_busy;
        end
    endtask

    task automatic check_run(input string nm, input int nresp, input bit ev, input logic [63:0] em,
                             input int et, input int ew, input bit etmo);
        int          starts, when, gtries;
        bit          gv, gf, gtmo, after;
        logic [63:0] gmap;
        run_req(nresp, starts, gv, gf, when, gmap, gtries, gtmo, after);
        chk({nm, " valid"}, 64'(gv), 64'(ev));
        chk({nm, " fail"}, 64'(gf), 64'(!ev));
        chk({nm, " latency"}, 64'(when), 64'(ew));
        chk({nm, " map"}, gmap, em);
        chk({nm, " tries"}, 64'(gtries), 64'(et));
        chk({nm, " starts"}, 64'(starts), 64'(et));
        chk({nm, " timeout"}, 64'(gtmo), 64'(etmo));
        chk({nm, " pulse_width"}, 64'(after), 64'd0);
    endtask

    task automatic idle_watch(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            pulses += int'(o_valid) + int'(o_fail) + int'(o_sample_start) + int'(o_busy);
        end
    endtask

    initial begin
        int          pulses;
        bit          ev;
        int          et, ew;
        logic [63:0] em;

        i_rst = 1'b1; i_req = 1'b0; i_abort = 1'b0; i_sample_done = 1'b0; red = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                pats[0][r][c] = (r == 2 && c == 5) ? 4'd1 : 4'd4;
                pats[1][r][c] = 4'((8*r + c) % 16);
                pats[2][r][c] = ((8*r + c) % 2 == 1) ? 4'd4 : 4'd3;
                pats[3][r][c] = 4'd0;
                pats[4][r][c] = 4'd15;
            end

        vecs[0] = '{sel:{3'd0,3'd0,3'd0,3'd0}, lat:1, ev:1'b1, em:64'hFFFF_FFFF_FFDF_FFFF, et:3, ew:11};
        vecs[1] = '{sel:{3'd2,3'd2,3'd2,3'd1}, lat:2, ev:1'b1, em:64'hAAAA_AAAA_AAAA_AAAA, et:4, ew:18};
        vecs[2] = '{sel:{3'd2,3'd1,3'd2,3'd1}, lat:3, ev:1'b0, em:64'hAAAA_AAAA_AAAA_AAAA, et:4, ew:21};
        vecs[3] = '{sel:{3'd3,3'd3,3'd3,3'd3}, lat:1, ev:1'b1, em:64'h0000_0000_0000_0000, et:3, ew:11};
        vecs[4] = '{sel:{3'd4,3'd4,3'd3,3'd4}, lat:2, ev:1'b0, em:64'h0000_0000_0000_0000, et:4, ew:17};
        vecs[5] = '{sel:{3'd4,3'd4,3'd4,3'd3}, lat:1, ev:1'b1, em:64'hFFFF_FFFF_FFFF_FFFF, et:4, ew:14};

        repeat (3) tick();
        i_rst = 1'b0;
        chk("reset start", 64'(o_sample_start), 64'd0);
        chk("reset map", o_map, 64'd0);
        chk("reset valid", 64'(o_valid), 64'd0);
        chk("reset fail", 64'(o_fail), 64'd0);
        chk("reset timeout", 64'(o_timeout), 64'd0);
        chk("reset busy", 64'(o_busy), 64'd0);
        chk("reset tries", 64'(o_tries), 64'd0);
        tick();

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < MT; i++) begin
                rsel[i] = vecs[v].sel[i];
                rlat[i] = vecs[v].lat;
            end
            check_run($sformatf("vec%0d", v), MT, vecs[v].ev, vecs[v].em,
                      vecs[v].et, vecs[v].ew, 1'b0);
        end
        mdl_map = 64'hFFFF_FFFF_FFFF_FFFF;

        // Sampler never answers: fail 100 cycles after the first WAIT cycle.
        check_run("timeout", 0, 1'b0, mdl_map, 1, 2 + TO, 1'b1);
        i_req = 1'b1;
        tick();
        i_req = 1'b0;
        chk("timeout cleared by req", 64'(o_timeout), 64'd0);
        chk("busy after req", 64'(o_busy), 64'd1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort from start busy", 64'(o_busy), 64'd0);
        tick();

        // Abort mid-WAIT, with a request while busy and a late done.
        i_req = 1'b1;
        tick();
        chk("abort seq start pulse", 64'(o_sample_start), 64'd1);
        tick();
        pulses = int'(o_sample_start);
        tick();
        pulses += int'(o_sample_start);
        i_req = 1'b0;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("req while busy ignored", 64'(pulses), 64'd0);
        chk("abort busy drop", 64'(o_busy), 64'd0);
        i_sample_done = 1'b1;
        red = pats[3];
        tick();
        i_sample_done = 1'b0;
        idle_watch(8, pulses);
        chk("late done ignored", 64'(pulses), 64'd0);
        chk("abort map held", o_map, mdl_map);
        chk("abort timeout held", 64'(o_timeout), 64'd0);

        for (int n = 0; n < 40; n++) begin
            if (n % 8 == 0) begin
                for (int p = 5; p < 8; p++)
                    for (int r = 0; r < 8; r++)
                        for (int c = 0; c < 8; c++)
                            pats[p][r][c] = 4'($urandom_range(0, 15));
            end
            for (int i = 0; i < MT; i++) begin
                rsel[i] = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'(5 + $urandom_range(0, 1));
                rlat[i] = $urandom_range(1, 6);
            end
            model(ev, et, em, ew);
            check_run($sformatf("rand%0d", n), MT, ev, em, et, ew, 1'b0);
            if (ev) mdl_map = em;
            repeat ($urandom_range(0, 3)) tick();
        end

        // Reset in the middle of WAIT clears everything at once.
        i_req = 1'b1;
        tick();
        i_req = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("midrst busy", 64'(o_busy), 64'd0);
        chk("midrst map", o_map, 64'd0);
        chk("midrst tries", 64'(o_tries), 64'd0);
        chk("midrst pulses", 64'({o_valid, o_fail, o_sample_start, o_timeout}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
